dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/core_pkg.sv | 50 +++++
 rtl/dmem_sram.sv | 39 +++
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Brief    : Shared types for the data-memory responder: load/store funct3
//             encodings, responder FSM states and the request bundle.
//  Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Load funct3 encodings (RV64 names kept so unsupported ones can be named)
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LD  = 3'b011,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101,
    LD_LWU = 3'b110
  } ld_op_t;

  // Store funct3 encodings
  typedef enum logic [2:0] {
    SD_SB = 3'b000,
    SD_SH = 3'b001,
    SD_SW = 3'b010,
    SD_SD = 3'b011
  } sd_op_t;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Access size as carried in funct3[1:0]
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // One load/store request as presented by the core
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_sram
//  Brief    : Single-port word SRAM, synchronous 1-cycle read, per-byte
//             write enables. Contents are never reset.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_sram #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write or registered read of the addressed word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Valid/ready data-memory slave. Decodes load/store requests,
//             flags unsupported/misaligned/out-of-range accesses, steers
//             byte lanes into the SRAM and formats load data.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import core_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  dmem_state_t   state;
  dmem_state_t   state_nxt;
  dmem_req_t     w_req;
  logic          w_accept;
  logic          w_bad_op;
  logic          w_misalign;
  logic          w_out_of_range;
  logic          w_err;
  logic [1:0]    w_size;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_index;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_mem_en;
  logic          w_mem_we;
  logic [31:0]   sram_rdata;
  logic [2:0]    r_funct3;
  logic [1:0]    r_lane;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;

  assign w_req = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

  assign w_accept = req_valid && req_ready;
  assign w_size   = w_req.funct3[1:0];

  // Offset from the window base; wraps below BASE_ADDR so one compare covers both ends
  assign w_offset       = w_req.addr - BASE_ADDR;
  assign w_out_of_range = ({1'b0, w_offset} >= SPAN);
  assign w_index        = w_offset[AW+1:2];

  // Reject funct3 codes this 32-bit memory does not implement
  always_comb begin
    w_bad_op = 1'b1;
    if (w_req.we) begin
      case (w_req.funct3)
        SD_SB, SD_SH, SD_SW: w_bad_op = 1'b0;
        default:             w_bad_op = 1'b1;
      endcase
    end else begin
      case (w_req.funct3)
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: w_bad_op = 1'b0;
        default:                             w_bad_op = 1'b1;
      endcase
    end
  end

  // Natural alignment check for halfword and word accesses
  always_comb begin
    w_misalign = 1'b0;
    if (w_size == SIZE_HALF) begin
      w_misalign = w_req.addr[0];
    end else if (w_size == SIZE_WORD) begin
      w_misalign = (w_req.addr[1:0] != 2'b00);
    end
  end

  assign w_err = w_bad_op || w_misalign || w_out_of_range;

  // Store byte enables and lane replication of LSB-aligned store data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_req.wdata;
    case (w_size)
      SIZE_BYTE: begin
        w_be    = 4'b0001 << w_req.addr[1:0];
        w_wdata = {4{w_req.wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_be    = 4'b0011 << w_req.addr[1:0];
        w_wdata = {2{w_req.wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = w_req.wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: errors and stores answer directly, loads pass through DATA
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (w_accept) begin
          state_nxt = (w_err || w_req.we) ? RESP : DATA;
        end
      end
      DATA:    state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; req_ready is also masked by reset so nothing is taken while held
  always_comb begin
    req_ready = rst_n && (state == IDLE);
    rsp_valid = (state == RESP);
    w_mem_en  = w_accept && !w_err;
    w_mem_we  = w_req.we;
  end

  // Response registers and load formatting context captured at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_funct3  <= '0;
      r_lane    <= '0;
    end else if (w_accept) begin
      rsp_rdata <= '0;
      rsp_err   <= w_err;
      r_funct3  <= w_req.funct3;
      r_lane    <= w_req.addr[1:0];
    end else if (state == DATA) begin
      rsp_rdata <= w_load_data;
    end
  end

  // Pick the addressed byte / halfword out of the fetched word
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = sram_rdata[7:0];
      2'd1:    w_byte = sram_rdata[15:8];
      2'd2:    w_byte = sram_rdata[23:16];
      default: w_byte = sram_rdata[31:24];
    endcase
    w_half = r_lane[1] ? sram_rdata[31:16] : sram_rdata[15:0];
  end

  // Sign- or zero-extend according to the captured load opcode
  always_comb begin
    case (r_funct3)
      LD_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      LD_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      LD_LW:   w_load_data = sram_rdata;
      LD_LBU:  w_load_data = {24'h0, w_byte};
      LD_LHU:  w_load_data = {16'h0, w_half};
      default: w_load_data = '0;
    endcase
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (w_mem_we),
    .be    (w_be),
    .addr  (w_index),
    .wdata (w_wdata),
    .rdata (sram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Directed self-checking bench for dmem_responder (default
//             parameters: 1024 words at byte address 0).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_D  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_WU = 3'b110;
  localparam logic [2:0] F_7  = 3'b111;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Issue one request with rsp_ready held high; report cycles from accept to rsp_valid
  task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ready/valid/err/rdata got %b/%b/%b/%h expected 0/0/0/00000000",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_word();
    vec_t v[2];
    int lat; logic [31:0] rd; logic er;
    v[0] = '{1'b1, F_W, 32'h10, 32'hDEADBEEF, 1, 32'h0,        1'b0};
    v[1] = '{1'b0, F_W, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0};
    foreach (v[i]) begin
      transact(v[i].we, v[i].f3, v[i].addr, v[i].wd, lat, rd, er);
      checks++;
      if (lat !== v[i].lat || rd !== v[i].rd || er !== v[i].err) begin
        fails++;
        $display("FAIL word[%0d]: lat/rdata/err got %0d/%h/%b expected %0d/%h/%b",
                 i, lat, rd, er, v[i].lat, v[i].rd, v[i].err);
      end
    end
  endtask

  // Word at 0x10 becomes 80_AD_BE_EF after the byte store (little-endian lanes)
  task automatic test_byte_half();
    vec_t v[7];
    int lat; logic [31:0] rd; logic er;
    v[0] = '{1'b1, F_B,  32'h13, 32'h00000080, 1, 32'h0,        1'b0};
    v[1] = '{1'b0, F_B,  32'h13, 32'h0,        2, 32'hFFFFFF80, 1'b0};
    v[2] = '{1'b0, F_BU, 32'h13, 32'h0,        2, 32'h00000080, 1'b0};
    v[3] = '{1'b0, F_H,  32'h12, 32'h0,        2, 32'hFFFF80AD, 1'b0};
    v[4] = '{1'b0, F_HU, 32'h10, 32'h0,        2, 32'h0000BEEF, 1'b0};
    v[5] = '{1'b0, F_B,  32'h11, 32'h0,        2, 32'hFFFFFFBE, 1'b0};
    v[6] = '{1'b0, F_W,  32'h10, 32'h0,        2, 32'h80ADBEEF, 1'b0};
    foreach (v[i]) begin
      transact(v[i].we, v[i].f3, v[i].addr, v[i].wd, lat, rd, er);
      checks++;
      if (lat !== v[i].lat || rd !== v[i].rd || er !== v[i].err) begin
        fails++;
        $display("FAIL byte_half[%0d]: lat/rdata/err got %0d/%h/%b expected %0d/%h/%b",
                 i, lat, rd, er, v[i].lat, v[i].rd, v[i].err);
      end
    end
  endtask

  task automatic test_misaligned();
    vec_t v[8];
    int lat; logic [31:0] rd; logic er;
    v[0] = '{1'b1, F_W,  32'h20, 32'h12345678, 1, 32'h0,        1'b0};
    v[1] = '{1'b0, F_W,  32'h11, 32'h0,        1, 32'h0,        1'b1};
    v[2] = '{1'b1, F_H,  32'h21, 32'hFFFF9999, 1, 32'h0,        1'b1};
    v[3] = '{1'b0, F_W,  32'h20, 32'h0,        2, 32'h12345678, 1'b0};
    v[4] = '{1'b1, F_H,  32'h22, 32'hFFFFA5C3, 1, 32'h0,        1'b0};
    v[5] = '{1'b0, F_W,  32'h20, 32'h0,        2, 32'hA5C35678, 1'b0};
    v[6] = '{1'b0, F_H,  32'h22, 32'h0,        2, 32'hFFFFA5C3, 1'b0};
    v[7] = '{1'b0, F_HU, 32'h23, 32'h0,        1, 32'h0,        1'b1};
    foreach (v[i]) begin
      transact(v[i].we, v[i].f3, v[i].addr, v[i].wd, lat, rd, er);
      checks++;
      if (lat !== v[i].lat || rd !== v[i].rd || er !== v[i].err) begin
        fails++;
        $display("FAIL misaligned[%0d]: lat/rdata/err got %0d/%h/%b expected %0d/%h/%b",
                 i, lat, rd, er, v[i].lat, v[i].rd, v[i].err);
      end
    end
  endtask

  task automatic test_unsupported_range();
    vec_t v[10];
    int lat; logic [31:0] rd; logic er;
    v[0] = '{1'b0, F_D,  32'h0,        32'h0,        1, 32'h0,        1'b1};
    v[1] = '{1'b0, F_WU, 32'h0,        32'h0,        1, 32'h0,        1'b1};
    v[2] = '{1'b0, F_7,  32'h0,        32'h0,        1, 32'h0,        1'b1};
    v[3] = '{1'b1, F_D,  32'h20,       32'h0BAD0BAD, 1, 32'h0,        1'b1};
    v[4] = '{1'b1, F_W,  32'hFFC,      32'h5A5A5A5A, 1, 32'h0,        1'b0};
    v[5] = '{1'b0, F_W,  32'hFFC,      32'h0,        2, 32'h5A5A5A5A, 1'b0};
    v[6] = '{1'b0, F_W,  32'h1000,     32'h0,        1, 32'h0,        1'b1};
    v[7] = '{1'b1, F_B,  32'h1000,     32'h000000EE, 1, 32'h0,        1'b1};
    v[8] = '{1'b0, F_B,  32'hFFFFFFFF, 32'h0,        1, 32'h0,        1'b1};
    v[9] = '{1'b0, F_W,  32'h20,       32'h0,        2, 32'hA5C35678, 1'b0};
    foreach (v[i]) begin
      transact(v[i].we, v[i].f3, v[i].addr, v[i].wd, lat, rd, er);
      checks++;
      if (lat !== v[i].lat || rd !== v[i].rd || er !== v[i].err) begin
        fails++;
        $display("FAIL unsupported_range[%0d]: lat/rdata/err got %0d/%h/%b expected %0d/%h/%b",
                 i, lat, rd, er, v[i].lat, v[i].rd, v[i].err);
      end
    end
  endtask

  // Load held in RESP by rsp_ready=0 while a store waits on the request port
  task automatic test_back_to_back_stall();
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h10; req_wdata = $urandom;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_idle_ready: got %b expected 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADF00D;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_data: valid/ready got %b/%b expected 0/0", rsp_valid, req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80ADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid/rdata/err/ready got %b/%h/%b/%b expected 1/80adbeef/0/0",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_after_handshake: valid/ready got %b/%b expected 0/1", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL stall_next_store: valid/err/rdata got %b/%b/%h expected 1/0/00000000",
               rsp_valid, rsp_err, rsp_rdata);
    end
    transact(1'b0, F_W, 32'h30, 32'h0, lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 32'h0BADF00D || er !== 1'b0) begin
      fails++;
      $display("FAIL stall_readback: lat/rdata/err got %0d/%h/%b expected 2/0badf00d/0", lat, rd, er);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    transact(1'b1, F_W, 32'h40, 32'hCAFEF00D, lat, rd, er);
    checks++;
    if (lat !== 1 || er !== 1'b0) begin
      fails++;
      $display("FAIL rst_prestore: lat/err got %0d/%b expected 1/0", lat, er);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h10; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h11111111;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_assert: valid/ready/err/rdata got %b/%b/%b/%h expected 0/0/0/00000000",
               rsp_valid, req_ready, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_held: valid/ready got %b/%b expected 0/0", rsp_valid, req_ready);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_release: ready/valid got %b/%b expected 1/0", req_ready, rsp_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_no_resp[%0d]: valid got %b expected 0", k, rsp_valid);
      end
    end
    transact(1'b0, F_W, 32'h40, 32'h0, lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_write: lat/rdata/err got %0d/%h/%b expected 2/cafef00d/0", lat, rd, er);
    end
    transact(1'b0, F_W, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 32'h80ADBEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL rst_mem_kept: lat/rdata/err got %0d/%h/%b expected 2/80adbeef/0", lat, rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misaligned();
    test_unsupported_range();
    test_back_to_back_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
